// File: rtl/vga_lockstep_if.sv
// Video bundle between the lockstep VGA source and its monitor.
// It carries the primary and redundant inputs, the re-driven pins and the status outputs.
interface vga_lockstep_if #(
   parameter int CNT_W = 16
);
   // primary and redundant video from the dual-lockstep peripheral
   logic             HSYNC;
   logic             VSYNC;
   logic [7:0]       RGB;
   logic             HSYNC_REDUN;
   logic             VSYNC_REDUN;
   logic [7:0]       RGB_REDUN;

   // pins and monitor status
   logic             VGA_HSYNC;
   logic             VGA_VSYNC;
   logic [7:0]       VGA_RGB;
   logic             DLS_FAULT;
   logic             TIMING_ERR;
   logic [CNT_W-1:0] MISMATCH_CNT;
   logic [11:0]      LINE_LEN;
   logic [15:0]      FRAME_CNT;
   logic [1:0]       STATE;

   modport master (
      output HSYNC, VSYNC, RGB, HSYNC_REDUN, VSYNC_REDUN, RGB_REDUN,
      input  VGA_HSYNC, VGA_VSYNC, VGA_RGB, DLS_FAULT, TIMING_ERR,
             MISMATCH_CNT, LINE_LEN, FRAME_CNT, STATE
   );

   modport slave (
      input  HSYNC, VSYNC, RGB, HSYNC_REDUN, VSYNC_REDUN, RGB_REDUN,
      output VGA_HSYNC, VGA_VSYNC, VGA_RGB, DLS_FAULT, TIMING_ERR,
             MISMATCH_CNT, LINE_LEN, FRAME_CNT, STATE
   );
endinterface

// File: rtl/vga_lockstep_monitor.sv
// Lockstep comparator and line/frame timing checker for a dual VGA source.
// Re-drives the primary video one cycle late and blanks the pixel once the
// primary and redundant copies have disagreed for MISMATCH_THRESH cycles in a row.
module vga_lockstep_monitor #(
   parameter int MISMATCH_THRESH = 1,
   parameter int EXP_LINE_CYCLES = 1600,
   parameter int EXP_FRAME_LINES = 525,
   parameter int CNT_W           = 16
) (
   input  logic          HCLK,
   input  logic          HRESET,
   input  logic          CLR,
   vga_lockstep_if.slave bus
);
   typedef enum logic [1:0] {
      ACQUIRE = 2'd0,
      TRACK   = 2'd1,
      FAULT   = 2'd2
   } state_t;

   localparam logic [7:0]  THRESH    = 8'(MISMATCH_THRESH);
   localparam logic [11:0] EXP_LINE  = 12'(EXP_LINE_CYCLES);
   localparam logic [15:0] EXP_FRAME = 16'(EXP_FRAME_LINES);

   // first input stage (all inputs) and second sync stage for edge detection
   logic             hsync_s1_reg;
   logic             vsync_s1_reg;
   logic [7:0]       rgb_s1_reg;
   logic             hsync_redun_s1_reg;
   logic             vsync_redun_s1_reg;
   logic [7:0]       rgb_redun_s1_reg;
   logic             hsync_s2_reg;
   logic             vsync_s2_reg;

   logic [7:0]       vga_rgb_reg;
   logic             dls_fault_reg;
   logic             dls_fault_next;
   logic [CNT_W-1:0] mismatch_cnt_reg;
   logic [7:0]       run_cnt_reg;

   logic [11:0]      line_cyc_reg;   // cycles since the last HSYNC fall
   logic [11:0]      line_len_reg;
   logic [15:0]      line_num_reg;   // HSYNC falls since the last VSYNC fall
   logic [15:0]      frame_cnt_reg;
   logic             vsync_seen_reg;
   logic             timing_err_reg;
   state_t           state_reg;

   logic             mismatch;
   logic             hsync_fall;
   logic             vsync_fall;
   logic             line_bad;
   logic             frame_bad;

   assign mismatch   = {hsync_s1_reg, vsync_s1_reg, rgb_s1_reg} !=
                       {hsync_redun_s1_reg, vsync_redun_s1_reg, rgb_redun_s1_reg};
   assign hsync_fall = hsync_s2_reg & ~hsync_s1_reg;
   assign vsync_fall = vsync_s2_reg & ~vsync_s1_reg;
   assign line_bad   = hsync_fall && (line_cyc_reg != EXP_LINE);
   assign frame_bad  = vsync_fall && vsync_seen_reg && (line_num_reg != EXP_FRAME);

   // the run has reached the threshold when this mismatch brings it to THRESH
   assign dls_fault_next = CLR ? 1'b0
                         : (dls_fault_reg | (mismatch && (run_cnt_reg >= THRESH - 8'd1)));

   // input registers; syncs idle high
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         hsync_s1_reg       <= 1'b1;
         vsync_s1_reg       <= 1'b1;
         rgb_s1_reg         <= 8'd0;
         hsync_redun_s1_reg <= 1'b1;
         vsync_redun_s1_reg <= 1'b1;
         rgb_redun_s1_reg   <= 8'd0;
         hsync_s2_reg       <= 1'b1;
         vsync_s2_reg       <= 1'b1;
      end else begin
         hsync_s1_reg       <= bus.HSYNC;
         vsync_s1_reg       <= bus.VSYNC;
         rgb_s1_reg         <= bus.RGB;
         hsync_redun_s1_reg <= bus.HSYNC_REDUN;
         vsync_redun_s1_reg <= bus.VSYNC_REDUN;
         rgb_redun_s1_reg   <= bus.RGB_REDUN;
         hsync_s2_reg       <= hsync_s1_reg;
         vsync_s2_reg       <= vsync_s1_reg;
      end
   end

   // output pixel register, blanked in step with the fault flag
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         vga_rgb_reg <= 8'd0;
      end else begin
         vga_rgb_reg <= dls_fault_next ? 8'd0 : bus.RGB;
      end
   end

   // lockstep compare: total mismatch count, current run and sticky fault
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         mismatch_cnt_reg <= '0;
         run_cnt_reg      <= 8'd0;
         dls_fault_reg    <= 1'b0;
      end else begin
         dls_fault_reg <= dls_fault_next;
         if (CLR) begin
            mismatch_cnt_reg <= '0;
            run_cnt_reg      <= 8'd0;
         end else if (mismatch) begin
            if (mismatch_cnt_reg != '1) begin
               mismatch_cnt_reg <= mismatch_cnt_reg + CNT_W'(1);
            end
            if (run_cnt_reg != 8'hFF) begin
               run_cnt_reg <= run_cnt_reg + 8'd1;
            end
         end else begin
            run_cnt_reg <= 8'd0;
         end
      end
   end

   // line length measurement and lines-per-frame counting
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         line_cyc_reg <= 12'd0;
         line_len_reg <= 12'd0;
         line_num_reg <= 16'd0;
      end else if (CLR) begin
         line_cyc_reg <= 12'd0;
         line_len_reg <= 12'd0;
         line_num_reg <= 16'd0;
      end else begin
         if (hsync_fall) begin
            line_len_reg <= line_cyc_reg;
            line_cyc_reg <= 12'd1;
         end else if (line_cyc_reg != 12'hFFF) begin
            line_cyc_reg <= line_cyc_reg + 12'd1;
         end
         // a coincident HSYNC fall is the first line of the new frame
         if (vsync_fall) begin
            line_num_reg <= hsync_fall ? 16'd1 : 16'd0;
         end else if (hsync_fall && line_num_reg != 16'hFFFF) begin
            line_num_reg <= line_num_reg + 16'd1;
         end
      end
   end

   // acquire/track/fault sequencing with timing error and good-frame count
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state_reg      <= ACQUIRE;
         timing_err_reg <= 1'b0;
         frame_cnt_reg  <= 16'd0;
         vsync_seen_reg <= 1'b0;
      end else if (CLR) begin
         state_reg      <= ACQUIRE;
         timing_err_reg <= 1'b0;
         frame_cnt_reg  <= 16'd0;
         vsync_seen_reg <= 1'b0;
      end else begin
         case (state_reg)
            ACQUIRE: begin
               // the first edge only establishes line phase
               if (hsync_fall) begin
                  state_reg      <= TRACK;
                  vsync_seen_reg <= 1'b0;
               end
            end
            TRACK: begin
               if (line_bad || frame_bad) begin
                  timing_err_reg <= 1'b1;
                  state_reg      <= FAULT;
               end else if (vsync_fall) begin
                  // the first VSYNC only opens a frame; later ones close one
                  if (!vsync_seen_reg) begin
                     vsync_seen_reg <= 1'b1;
                  end else begin
                     frame_cnt_reg <= frame_cnt_reg + 16'd1;
                  end
               end
            end
            FAULT: begin
               state_reg <= FAULT;
            end
            default: begin
               state_reg <= ACQUIRE;
            end
         endcase
      end
   end

   assign bus.VGA_HSYNC    = hsync_s1_reg;
   assign bus.VGA_VSYNC    = vsync_s1_reg;
   assign bus.VGA_RGB      = vga_rgb_reg;
   assign bus.DLS_FAULT    = dls_fault_reg;
   assign bus.TIMING_ERR   = timing_err_reg;
   assign bus.MISMATCH_CNT = mismatch_cnt_reg;
   assign bus.LINE_LEN     = line_len_reg;
   assign bus.FRAME_CNT    = frame_cnt_reg;
   assign bus.STATE        = state_reg;
endmodule

// File: tb/tb_vga_lockstep_monitor.sv
// Bench for vga_lockstep_monitor: two instances (threshold 1 / 16-bit counter and
// threshold 3 / 8-bit counter) share one stimulus stream with shortened video
// timing; every cycle is compared against a model built on edge indices.
module tb_vga_lockstep_monitor;
   localparam int EXP_L = 40;
   localparam int EXP_F = 6;
   localparam int HS_W  = 4;
   localparam int CNT_A = 16;
   localparam int CNT_B = 8;

   logic HCLK   = 1'b0;
   logic HRESET = 1'b1;
   logic CLR    = 1'b0;

   vga_lockstep_if #(.CNT_W(CNT_A)) bus_a ();
   vga_lockstep_if #(.CNT_W(CNT_B)) bus_b ();

   vga_lockstep_monitor #(
      .MISMATCH_THRESH(1), .EXP_LINE_CYCLES(EXP_L), .EXP_FRAME_LINES(EXP_F), .CNT_W(CNT_A)
   ) dut_a (.HCLK(HCLK), .HRESET(HRESET), .CLR(CLR), .bus(bus_a));

   vga_lockstep_monitor #(
      .MISMATCH_THRESH(3), .EXP_LINE_CYCLES(EXP_L), .EXP_FRAME_LINES(EXP_F), .CNT_W(CNT_B)
   ) dut_b (.HCLK(HCLK), .HRESET(HRESET), .CLR(CLR), .bus(bus_b));

   always #5 HCLK = ~HCLK;

   typedef struct packed {
      logic       h;
      logic       v;
      logic [7:0] rgb;
      logic       hr;
      logic       vr;
      logic [7:0] rgbr;
   } pins_t;

   localparam pins_t IDLE = '{h: 1'b1, v: 1'b1, rgb: 8'd0, hr: 1'b1, vr: 1'b1, rgbr: 8'd0};

   int n_checks = 0;
   int n_errors = 0;

   // reference model: pin snapshots at the last two edges plus plain counters
   pins_t  cur, seen, older;
   int     m_edge = 0;
   int     m_anchor;        // edge after which the line counter read 0
   int     m_line_len;
   int     m_lines;
   int     m_frames;
   bit     m_vseen;
   bit     m_terr;
   int     m_state;
   longint m_cnt   [2];
   int     m_run   [2];
   bit     m_fault [2];
   int     thresh  [2] = '{1, 3};
   longint cmax    [2] = '{65535, 255};

   bit hold_rst = 1'b1;
   bit vlevel   = 1'b1;
   bit rnd_flip = 1'b0;
   int line_no  = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_cnt[k]   = 0;
         m_run[k]   = 0;
         m_fault[k] = 1'b0;
      end
      m_anchor   = m_edge;
      m_line_len = 0;
      m_lines    = 0;
      m_frames   = 0;
      m_vseen    = 1'b0;
      m_terr     = 1'b0;
      m_state    = 0;
      seen       = IDLE;
      older      = IDLE;
   endtask

   task automatic model_edge();
      bit mism, hf, vf, lerr, ferr;
      int pre;
      m_edge++;
      if (HRESET) begin
         model_reset();
         return;
      end
      mism = {seen.h, seen.v, seen.rgb} != {seen.hr, seen.vr, seen.rgbr};
      hf   = older.h && !seen.h;
      vf   = older.v && !seen.v;
      if (CLR) begin
         for (int k = 0; k < 2; k++) begin
            m_cnt[k]   = 0;
            m_run[k]   = 0;
            m_fault[k] = 1'b0;
         end
         m_anchor   = m_edge;
         m_line_len = 0;
         m_lines    = 0;
         m_frames   = 0;
         m_vseen    = 1'b0;
         m_terr     = 1'b0;
         m_state    = 0;
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (mism) begin
               if (m_cnt[k] < cmax[k]) m_cnt[k]++;
               m_run[k]++;
               if (m_run[k] >= thresh[k]) m_fault[k] = 1'b1;
            end else begin
               m_run[k] = 0;
            end
         end
         pre = m_edge - 1 - m_anchor;
         if (pre > 4095) pre = 4095;
         lerr = hf && (pre != EXP_L);
         ferr = vf && m_vseen && (m_lines != EXP_F);
         if (m_state == 0) begin
            if (hf) begin
               m_state = 1;
               m_vseen = 1'b0;
            end
         end else if (m_state == 1) begin
            if (lerr || ferr) begin
               m_terr  = 1'b1;
               m_state = 2;
            end else if (vf) begin
               if (!m_vseen) m_vseen = 1'b1;
               else          m_frames = (m_frames + 1) % 65536;
            end
         end
         if (hf) begin
            m_line_len = pre;
            m_anchor   = m_edge - 1;
         end
         if (vf)      m_lines = hf ? 1 : 0;
         else if (hf) m_lines++;
      end
      older = seen;
      seen  = cur;
   endtask

   task automatic check_all();
      chk("a_hsync",  bus_a.VGA_HSYNC,    seen.h);
      chk("a_vsync",  bus_a.VGA_VSYNC,    seen.v);
      chk("a_rgb",    bus_a.VGA_RGB,      m_fault[0] ? 8'd0 : seen.rgb);
      chk("a_dls",    bus_a.DLS_FAULT,    m_fault[0]);
      chk("a_mcnt",   bus_a.MISMATCH_CNT, m_cnt[0]);
      chk("a_terr",   bus_a.TIMING_ERR,   m_terr);
      chk("a_linlen", bus_a.LINE_LEN,     m_line_len);
      chk("a_frames", bus_a.FRAME_CNT,    m_frames);
      chk("a_state",  bus_a.STATE,        m_state);
      chk("b_hsync",  bus_b.VGA_HSYNC,    seen.h);
      chk("b_rgb",    bus_b.VGA_RGB,      m_fault[1] ? 8'd0 : seen.rgb);
      chk("b_dls",    bus_b.DLS_FAULT,    m_fault[1]);
      chk("b_mcnt",   bus_b.MISMATCH_CNT, m_cnt[1]);
      chk("b_terr",   bus_b.TIMING_ERR,   m_terr);
      chk("b_linlen", bus_b.LINE_LEN,     m_line_len);
      chk("b_frames", bus_b.FRAME_CNT,    m_frames);
      chk("b_state",  bus_b.STATE,        m_state);
   endtask

   task automatic cycle(input pins_t p, input logic clr);
      cur = p;
      bus_a.HSYNC = p.h;  bus_a.VSYNC = p.v;  bus_a.RGB = p.rgb;
      bus_a.HSYNC_REDUN = p.hr;  bus_a.VSYNC_REDUN = p.vr;  bus_a.RGB_REDUN = p.rgbr;
      bus_b.HSYNC = p.h;  bus_b.VSYNC = p.v;  bus_b.RGB = p.rgb;
      bus_b.HSYNC_REDUN = p.hr;  bus_b.VSYNC_REDUN = p.vr;  bus_b.RGB_REDUN = p.rgbr;
      CLR    = clr;
      HRESET = hold_rst;
      @(posedge HCLK);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic idle(input int n, input int clr_at, input bit mism);
      pins_t p;
      vlevel = 1'b1;
      for (int c = 0; c < n; c++) begin
         p = IDLE;
         p.rgb  = 8'($urandom);
         p.rgbr = p.rgb;
         if (mism) begin
            p.rgb  = 8'h54;
            p.rgbr = 8'h55;
         end
         cycle(p, c == clr_at);
      end
   endtask

   task automatic send_line(input int len, input int voff, input int vrise,
                            input int inj_at, input int inj_len, input int clr_at);
      pins_t p;
      for (int c = 0; c < len; c++) begin
         if (c == voff)  vlevel = 1'b0;
         if (c == vrise) vlevel = 1'b1;
         p.h    = (c >= HS_W);
         p.v    = vlevel;
         p.rgb  = 8'($urandom);
         p.hr   = p.h;
         p.vr   = p.v;
         p.rgbr = p.rgb;
         if (inj_at >= 0 && c >= inj_at && c < inj_at + inj_len) begin
            p.rgb  = 8'h54;
            p.rgbr = 8'h55;
         end
         if (rnd_flip && $urandom_range(0, 99) == 0) begin
            case ($urandom_range(0, 2))
               0:       p.hr = ~p.hr;
               1:       p.vr = ~p.vr;
               default: p.rgbr = p.rgbr ^ (8'h01 << $urandom_range(0, 7));
            endcase
         end
         cycle(p, c == clr_at);
      end
      line_no++;
      $display("line %0d len=%0d state=%0d line_len=%0d frames=%0d dls_a=%0d mcnt_a=%0d",
               line_no, len, bus_a.STATE, bus_a.LINE_LEN, bus_a.FRAME_CNT,
               bus_a.DLS_FAULT, bus_a.MISMATCH_CNT);
   endtask

   task automatic send_frame(input int nlines, input int voff, input int short_idx,
                             input int short_len);
      for (int l = 0; l < nlines; l++) begin
         send_line((l == short_idx) ? short_len : EXP_L, (l == 0) ? voff : -1,
                   (l == 2) ? 0 : -1, -1, 0, -1);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      pins_t p;
      int    len;
      cur = IDLE;
      model_reset();

      // reset state
      hold_rst = 1'b1;
      idle(3, -1, 0);
      chk("rst_state", bus_a.STATE, 2'd0);
      chk("rst_rgb", bus_a.VGA_RGB, 8'd0);
      hold_rst = 1'b0;
      idle(5, -1, 0);

      // three clean frames
      for (int f = 0; f < 3; f++) send_frame(EXP_F, 10, -1, 0);
      chk("good_state", bus_a.STATE, 2'd1);
      chk("good_frames", bus_a.FRAME_CNT, 16'd2);
      chk("good_linelen", bus_a.LINE_LEN, 12'd40);
      chk("good_terr", bus_a.TIMING_ERR, 1'b0);
      chk("good_dls", bus_a.DLS_FAULT, 1'b0);

      // single-cycle mismatch
      send_line(EXP_L, -1, -1, 20, 1, -1);
      send_line(EXP_L, -1, -1, -1, 0, -1);
      chk("mm1_cnt_a", bus_a.MISMATCH_CNT, 16'd1);
      chk("mm1_dls_a", bus_a.DLS_FAULT, 1'b1);
      chk("mm1_rgb_a", bus_a.VGA_RGB, 8'd0);
      chk("mm1_dls_b", bus_b.DLS_FAULT, 1'b0);

      // threshold 3: runs of 2 then 3
      idle(3, 0, 0);
      send_line(EXP_L, -1, -1, 10, 2, -1);
      chk("mm3_dls_b_run2", bus_b.DLS_FAULT, 1'b0);
      chk("mm3_cnt_b_run2", bus_b.MISMATCH_CNT, 8'd2);
      send_line(EXP_L, -1, -1, 10, 3, -1);
      chk("mm3_cnt_b", bus_b.MISMATCH_CNT, 8'd5);
      chk("mm3_dls_b", bus_b.DLS_FAULT, 1'b1);
      chk("mm3_cnt_a", bus_a.MISMATCH_CNT, 16'd5);

      // counter saturation, then CLR against a pending mismatch
      idle(300, -1, 1);
      chk("sat_cnt_b", bus_b.MISMATCH_CNT, 8'hFF);
      idle(3, 0, 0);
      chk("clr_cnt_b", bus_b.MISMATCH_CNT, 8'd0);
      chk("clr_dls_b", bus_b.DLS_FAULT, 1'b0);
      chk("clr_cnt_a", bus_a.MISMATCH_CNT, 16'd0);

      // short line while tracking
      send_line(EXP_L, -1, -1, -1, 0, -1);
      send_frame(EXP_F, 10, -1, 0);
      send_line(EXP_L - 1, -1, -1, -1, 0, -1);
      send_line(8, -1, -1, -1, 0, -1);
      chk("short_linelen", bus_a.LINE_LEN, 12'd39);
      chk("short_terr", bus_a.TIMING_ERR, 1'b1);
      chk("short_state", bus_a.STATE, 2'd2);
      idle(2, 0, 0);
      chk("clr_state", bus_a.STATE, 2'd0);
      chk("clr_terr", bus_a.TIMING_ERR, 1'b0);
      send_line(EXP_L, -1, -1, -1, 0, -1);
      chk("reacq_state", bus_a.STATE, 2'd1);

      // frame one line short after the first VSYNC
      send_frame(EXP_F - 1, 10, -1, 0);
      send_line(EXP_L, 10, -1, -1, 0, -1);
      chk("frame_terr", bus_a.TIMING_ERR, 1'b1);
      chk("frame_state", bus_a.STATE, 2'd2);
      chk("frame_cnt0", bus_a.FRAME_CNT, 16'd0);

      // VSYNC falling together with HSYNC
      idle(3, 0, 0);
      send_line(EXP_L, -1, -1, -1, 0, -1);
      for (int f = 0; f < 3; f++) send_frame(EXP_F, 0, -1, 0);
      chk("coinc_terr", bus_a.TIMING_ERR, 1'b0);
      chk("coinc_frames", bus_a.FRAME_CNT, 16'd2);
      chk("coinc_state", bus_a.STATE, 2'd1);

      // randomized stream with occasional redundant corruption and line jitter
      rnd_flip = 1'b1;
      for (int f = 0; f < 4; f++) begin
         for (int l = 0; l < EXP_F; l++) begin
            len = EXP_L;
            if ($urandom_range(0, 7) == 0) len = ($urandom_range(0, 1) != 0) ? EXP_L + 1 : EXP_L - 1;
            send_line(len, (l == 0) ? 10 : -1, (l == 2) ? 0 : -1, -1, 0, -1);
         end
      end
      rnd_flip = 1'b0;

      // asynchronous reset in the middle of a line
      idle(3, 0, 0);
      send_line(EXP_L, -1, -1, -1, 0, -1);
      p = '{h: 1'b0, v: 1'b1, rgb: 8'hA5, hr: 1'b0, vr: 1'b1, rgbr: 8'hA5};
      cycle(p, 1'b0);
      cycle(p, 1'b0);
      #2;
      HRESET   = 1'b1;
      hold_rst = 1'b1;
      #1;
      model_reset();
      chk("arst_hsync", bus_a.VGA_HSYNC, 1'b1);
      chk("arst_rgb", bus_a.VGA_RGB, 8'd0);
      chk("arst_state", bus_a.STATE, 2'd0);
      chk("arst_linelen", bus_b.LINE_LEN, 12'd0);
      idle(2, -1, 0);
      hold_rst = 1'b0;
      idle(3, -1, 0);
      send_line(EXP_L, -1, -1, -1, 0, -1);
      send_frame(EXP_F, 10, -1, 0);
      send_frame(EXP_F, 10, -1, 0);
      chk("rearm_state", bus_a.STATE, 2'd1);
      chk("rearm_frames", bus_a.FRAME_CNT, 16'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
